// File: rtl/debug_cmd_rx.sv
// Debug command receiver: decodes UART bytes into program-load, run/halt, step and dump actions.
// Define DEBUG_CMD_RX_CHECKSUM_EN to require a trailing XOR checksum byte after each LOAD.
module debug_cmd_rx (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_RX_EMPTY,
   input  logic [7:0]  I_DATA_UART,
   output logic        O_RD_UART,
   output logic        O_IM_WE,
   output logic [9:0]  O_IM_ADDR,
   output logic [31:0] O_IM_DATA,
   output logic        O_CPU_EN,
   output logic        O_STEP,
   output logic        O_DUMP_REQ,
   output logic        O_LOADING,
   output logic        O_ERR
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD_CNT   = 3'd1,
      LOAD_DATA  = 3'd2,
      LOAD_WRITE = 3'd3,
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
      LOAD_CHK   = 3'd4,
`endif
      STEP       = 3'd5,
      DUMP       = 3'd6
   } state_t;

   state_t      r_state;
   state_t      r_next;
   logic        r_cpuEn;
   logic        r_err;
   logic [8:0]  r_left;
   logic [7:0]  r_idx;
   logic [31:0] r_shift;
   logic [1:0]  r_byteCnt;
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
   logic [7:0]  r_chk;
`endif
   logic        w_avail;
   logic        w_pop;

   // Gating with RESET keeps the FIFO untouched while reset is held
   assign w_avail   = RESET & ~I_RX_EMPTY;
   assign O_RD_UART = w_pop;
   assign O_IM_ADDR = {r_idx, 2'b00};
   assign O_IM_DATA = r_shift;
   assign O_CPU_EN  = r_cpuEn;
   assign O_ERR     = r_err;

   always_ff @(posedge CLK) begin
      if (!RESET) r_state <= IDLE;
      else        r_state <= r_next;
   end

   always_comb begin
      r_next     = r_state;
      w_pop      = 1'b0;
      O_IM_WE    = 1'b0;
      O_STEP     = 1'b0;
      O_DUMP_REQ = 1'b0;
      O_LOADING  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_avail) begin
               w_pop = 1'b1;
               case (I_DATA_UART)
                  8'h01:   r_next = LOAD_CNT;
                  8'h03:   if (!r_cpuEn) r_next = STEP;
                  8'h05:   r_next = DUMP;
                  default: r_next = IDLE;
               endcase
            end
         end
         LOAD_CNT: begin
            O_LOADING = 1'b1;
            if (w_avail) begin
               w_pop  = 1'b1;
               r_next = LOAD_DATA;
            end
         end
         LOAD_DATA: begin
            O_LOADING = 1'b1;
            if (w_avail) begin
               w_pop = 1'b1;
               if (r_byteCnt == 2'd3) r_next = LOAD_WRITE;
            end
         end
         LOAD_WRITE: begin
            O_LOADING = 1'b1;
            O_IM_WE   = 1'b1;
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
            r_next = (r_left == 9'd1) ? LOAD_CHK : LOAD_DATA;
`else
            r_next = (r_left == 9'd1) ? IDLE : LOAD_DATA;
`endif
         end
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
         LOAD_CHK: begin
            O_LOADING = 1'b1;
            if (w_avail) begin
               w_pop  = 1'b1;
               r_next = IDLE;
            end
         end
`endif
         STEP: begin
            O_STEP = 1'b1;
            r_next = DUMP;
         end
         DUMP: begin
            O_DUMP_REQ = 1'b1;
            r_next     = IDLE;
         end
         default: r_next = IDLE;
      endcase
   end

   // Word count register holds the words still to write; a count byte of 0 means 256
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_cpuEn   <= 1'b0;
         r_err     <= 1'b0;
         r_left    <= 9'd0;
         r_idx     <= 8'd0;
         r_shift   <= 32'd0;
         r_byteCnt <= 2'd0;
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
         r_chk     <= 8'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  case (I_DATA_UART)
                     8'h01: begin
                        r_cpuEn   <= 1'b0;
                        r_err     <= 1'b0;
                        r_idx     <= 8'd0;
                        r_byteCnt <= 2'd0;
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
                        r_chk     <= 8'd0;
`endif
                     end
                     8'h02:   r_cpuEn <= 1'b1;
                     8'h04:   r_cpuEn <= 1'b0;
                     8'h03, 8'h05: ;
                     default: r_err <= 1'b1;
                  endcase
               end
            end
            LOAD_CNT: begin
               if (w_pop) r_left <= (I_DATA_UART == 8'd0) ? 9'd256 : {1'b0, I_DATA_UART};
            end
            LOAD_DATA: begin
               if (w_pop) begin
                  r_shift   <= {r_shift[23:0], I_DATA_UART};
                  r_byteCnt <= r_byteCnt + 2'd1;
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
                  r_chk     <= r_chk ^ I_DATA_UART;
`endif
               end
            end
            LOAD_WRITE: begin
               r_idx  <= r_idx + 8'd1;
               r_left <= r_left - 9'd1;
            end
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
            LOAD_CHK: begin
               if (w_pop && (I_DATA_UART != r_chk)) r_err <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_cmd_rx.sv
// Directed testbench for debug_cmd_rx; honours DEBUG_CMD_RX_CHECKSUM_EN when defined.
module tb_debug_cmd_rx;

   logic        CLK;
   logic        RESET;
   logic        I_RX_EMPTY;
   logic [7:0]  I_DATA_UART;
   logic        O_RD_UART;
   logic        O_IM_WE;
   logic [9:0]  O_IM_ADDR;
   logic [31:0] O_IM_DATA;
   logic        O_CPU_EN;
   logic        O_STEP;
   logic        O_DUMP_REQ;
   logic        O_LOADING;
   logic        O_ERR;

   int total = 0;
   int bad   = 0;

   debug_cmd_rx dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .I_RX_EMPTY  (I_RX_EMPTY),
      .I_DATA_UART (I_DATA_UART),
      .O_RD_UART   (O_RD_UART),
      .O_IM_WE     (O_IM_WE),
      .O_IM_ADDR   (O_IM_ADDR),
      .O_IM_DATA   (O_IM_DATA),
      .O_CPU_EN    (O_CPU_EN),
      .O_STEP      (O_STEP),
      .O_DUMP_REQ  (O_DUMP_REQ),
      .O_LOADING   (O_LOADING),
      .O_ERR       (O_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one byte at the FIFO head and returns 1ns after the edge that popped it
   task automatic applyStimulus(input logic [7:0] b);
      int waitCyc = 0;
      I_DATA_UART = b;
      I_RX_EMPTY  = 1'b0;
      #1;
      while (!O_RD_UART && waitCyc < 50) begin
         @(posedge CLK);
         #1;
         waitCyc++;
      end
      if (!O_RD_UART) begin
         checkOutput("pop_timeout", {31'd0, O_RD_UART}, 32'd1);
      end else begin
         @(posedge CLK);
         #1;
      end
      I_RX_EMPTY = 1'b1;
   endtask

   task automatic stepCycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [7:0] words[8];
      RESET       = 1'b0;
      I_RX_EMPTY  = 1'b1;
      I_DATA_UART = 8'h00;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("rst_rd",      {31'd0, O_RD_UART},  32'd0);
      checkOutput("rst_we",      {31'd0, O_IM_WE},    32'd0);
      checkOutput("rst_addr",    {22'd0, O_IM_ADDR},  32'd0);
      checkOutput("rst_data",    O_IM_DATA,           32'd0);
      checkOutput("rst_cpuen",   {31'd0, O_CPU_EN},   32'd0);
      checkOutput("rst_step",    {31'd0, O_STEP},     32'd0);
      checkOutput("rst_dump",    {31'd0, O_DUMP_REQ}, 32'd0);
      checkOutput("rst_loading", {31'd0, O_LOADING},  32'd0);
      checkOutput("rst_err",     {31'd0, O_ERR},      32'd0);
      RESET = 1'b1;
      stepCycle();
      checkOutput("idle_empty_rd", {31'd0, O_RD_UART}, 32'd0);

      // Two-word load
      words = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      applyStimulus(8'h01);
      checkOutput("load_loading", {31'd0, O_LOADING}, 32'd1);
      applyStimulus(8'h02);
      for (int i = 0; i < 4; i++) applyStimulus(words[i]);
      checkOutput("w0_we",   {31'd0, O_IM_WE},   32'd1);
      checkOutput("w0_addr", {22'd0, O_IM_ADDR}, 32'h000);
      checkOutput("w0_data", O_IM_DATA,          32'h12345678);
      I_DATA_UART = words[4];
      I_RX_EMPTY  = 1'b0;
      #1;
      checkOutput("w0_nopop", {31'd0, O_RD_UART}, 32'd0);
      for (int i = 4; i < 8; i++) applyStimulus(words[i]);
      checkOutput("w1_we",   {31'd0, O_IM_WE},   32'd1);
      checkOutput("w1_addr", {22'd0, O_IM_ADDR}, 32'h004);
      checkOutput("w1_data", O_IM_DATA,          32'h9ABCDEF0);
      stepCycle();
      checkOutput("w1_we_off", {31'd0, O_IM_WE}, 32'd0);
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
      checkOutput("chk_loading", {31'd0, O_LOADING}, 32'd1);
      applyStimulus(8'h00);
`endif
      checkOutput("load_done", {31'd0, O_LOADING}, 32'd0);
      checkOutput("load_err",  {31'd0, O_ERR},     32'd0);

      // Run, ignored step, halt
      applyStimulus(8'h02);
      checkOutput("run_cpuen", {31'd0, O_CPU_EN}, 32'd1);
      applyStimulus(8'h03);
      checkOutput("run_step0", {31'd0, O_STEP}, 32'd0);
      stepCycle();
      checkOutput("run_step1", {31'd0, O_STEP},     32'd0);
      checkOutput("run_dump1", {31'd0, O_DUMP_REQ}, 32'd0);
      checkOutput("run_err",   {31'd0, O_ERR},      32'd0);
      applyStimulus(8'h04);
      checkOutput("halt_cpuen", {31'd0, O_CPU_EN}, 32'd0);

      // Single step while halted
      applyStimulus(8'h03);
      checkOutput("step_pulse", {31'd0, O_STEP},     32'd1);
      checkOutput("step_dump0", {31'd0, O_DUMP_REQ}, 32'd0);
      stepCycle();
      checkOutput("step_off",   {31'd0, O_STEP},     32'd0);
      checkOutput("step_dump",  {31'd0, O_DUMP_REQ}, 32'd1);
      stepCycle();
      checkOutput("step_dump_off", {31'd0, O_DUMP_REQ}, 32'd0);

      // Bad command, dump keeps error, load clears it
      applyStimulus(8'h7F);
      checkOutput("bad_err",  {31'd0, O_ERR},     32'd1);
      checkOutput("bad_load", {31'd0, O_LOADING}, 32'd0);
      applyStimulus(8'h05);
      checkOutput("dump_pulse",  {31'd0, O_DUMP_REQ}, 32'd1);
      checkOutput("dump_errkept", {31'd0, O_ERR},     32'd1);
      applyStimulus(8'h01);
      checkOutput("load_errclr", {31'd0, O_ERR}, 32'd0);

      // Reset in the middle of a load
      applyStimulus(8'h03);
      applyStimulus(8'hAA);
      checkOutput("mid_loading", {31'd0, O_LOADING}, 32'd1);
      RESET = 1'b0;
      stepCycle();
      checkOutput("mrst_loading", {31'd0, O_LOADING},  32'd0);
      checkOutput("mrst_addr",    {22'd0, O_IM_ADDR},  32'd0);
      checkOutput("mrst_data",    O_IM_DATA,           32'd0);
      checkOutput("mrst_we",      {31'd0, O_IM_WE},    32'd0);
      checkOutput("mrst_err",     {31'd0, O_ERR},      32'd0);
      RESET = 1'b1;
      applyStimulus(8'h05);
      checkOutput("mrst_dump", {31'd0, O_DUMP_REQ}, 32'd1);
      stepCycle();

`ifdef DEBUG_CMD_RX_CHECKSUM_EN
      // Checksum mismatch then match
      applyStimulus(8'h01);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      checkOutput("cs_data", O_IM_DATA, 32'h00000001);
      applyStimulus(8'h00);
      checkOutput("cs_bad", {31'd0, O_ERR}, 32'd1);
      applyStimulus(8'h01);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      applyStimulus(8'h01);
      checkOutput("cs_good", {31'd0, O_ERR}, 32'd0);
`endif

      // Count byte 0 loads 256 words and the address wraps through 0x3FC
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      for (int w = 0; w < 256; w++) begin
         applyStimulus(8'h00);
         applyStimulus(8'h00);
         applyStimulus(8'h00);
         applyStimulus(w[7:0]);
         checkOutput("full_addr", {22'd0, O_IM_ADDR}, w * 4);
         checkOutput("full_data", O_IM_DATA, w);
      end
      stepCycle();
`ifdef DEBUG_CMD_RX_CHECKSUM_EN
      checkOutput("full_chk_loading", {31'd0, O_LOADING}, 32'd1);
      applyStimulus(8'h00);
      checkOutput("full_chk_err", {31'd0, O_ERR}, 32'd0);
`endif
      checkOutput("full_done", {31'd0, O_LOADING}, 32'd0);
      checkOutput("full_addr_wrap", {22'd0, O_IM_ADDR}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
